// File: rtl/spram32_arb_pkg.sv
// Shared types for the two-master SRAM arbiter.
package spram32_arb_pkg;

    localparam int unsigned RUN_W = 4;

    typedef logic [14:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  bmsk_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_e;

endpackage

// File: rtl/spram32_arb_pick.sv
// Fixed-priority grant selection with an anti-starvation run counter for M1.
module spram32_arb_pick
    import spram32_arb_pkg::*;
#(
    parameter int unsigned MAX_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output gnt_e gnt
);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;

    // Grant: M0 preferred unless M1 has waited through MAX_RUN M0 grants
    always_comb begin
        gnt = GNT_NONE;
        if (rst) begin
            gnt = GNT_NONE;
        end else if (req0 && req1) begin
            gnt = (run_cnt == RUN_W'(MAX_RUN)) ? GNT_M1 : GNT_M0;
        end else if (req0) begin
            gnt = GNT_M0;
        end else if (req1) begin
            gnt = GNT_M1;
        end
    end

    // Run counter: counts M0 grants while M1 waits, saturating at MAX_RUN
    always_comb begin
        run_cnt_nxt = run_cnt;
        if (!req1 || gnt == GNT_M1) begin
            run_cnt_nxt = '0;
        end else if (gnt == GNT_M0 && run_cnt < RUN_W'(MAX_RUN)) begin
            run_cnt_nxt = run_cnt + RUN_W'(1);
        end
    end

    // Run counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt_nxt;
        end
    end

endmodule

// File: rtl/spram32_arb.sv
// Two-master arbiter in front of a 32-bit single-port SRAM with 1-cycle read return.
module spram32_arb
    import spram32_arb_pkg::*;
#(
    parameter int unsigned AW      = 15,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [3:0]    bmsk0,
    input  logic [3:0]    bmsk1,
    input  logic [AW-1:0] ai0,
    input  logic [AW-1:0] ai1,
    input  logic [DW-1:0] vi0,
    input  logic [DW-1:0] vi1,
    output logic          ack0,
    output logic          ack1,
    output logic          rv0,
    output logic          rv1,
    output logic [DW-1:0] vo,
    output logic [AW-1:0] m_ai,
    output logic [DW-1:0] m_vi,
    output logic          m_we,
    output logic [3:0]    m_bmsk,
    input  logic [DW-1:0] m_vo
);

    gnt_e gnt;
    gnt_e pend;
    gnt_e pend_nxt;

    spram32_arb_pick #(
        .MAX_RUN (MAX_RUN)
    ) u_pick (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt  (gnt)
    );

    // Memory request mux; idle cycles present M0's address as a harmless read
    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        m_ai   = ai0;
        m_vi   = vi0;
        m_we   = 1'b0;
        m_bmsk = 4'b0000;
        pend_nxt = GNT_NONE;
        case (gnt)
            GNT_M0: begin
                ack0   = 1'b1;
                m_we   = we0;
                m_bmsk = we0 ? bmsk0 : 4'b0000;
                pend_nxt = we0 ? GNT_NONE : GNT_M0;
            end
            GNT_M1: begin
                ack1   = 1'b1;
                m_ai   = ai1;
                m_vi   = vi1;
                m_we   = we1;
                m_bmsk = we1 ? bmsk1 : 4'b0000;
                pend_nxt = we1 ? GNT_NONE : GNT_M1;
            end
            default: ;
        endcase
    end

    // Remember which master owns the read returning next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= GNT_NONE;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Read valid pulses; a reset arriving while a read is in flight kills its return
    always_comb begin
        rv0 = !rst && (pend == GNT_M0);
        rv1 = !rst && (pend == GNT_M1);
    end

    assign vo = m_vo;

endmodule

// File: tb/tb_spram32_arb.sv
// Directed bench for spram32_arb with a behavioural registered-output SRAM.
module tb_spram32_arb;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [3:0]  bmsk0, bmsk1;
    logic [14:0] ai0, ai1;
    logic [31:0] vi0, vi1;
    logic        ack0, ack1, rv0, rv1;
    logic [31:0] vo;
    logic [14:0] m_ai;
    logic [31:0] m_vi;
    logic        m_we;
    logic [3:0]  m_bmsk;
    logic [31:0] m_vo;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:32767];

    spram32_arb #(.AW(15), .DW(32), .MAX_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .bmsk0(bmsk0), .bmsk1(bmsk1), .ai0(ai0), .ai1(ai1),
        .vi0(vi0), .vi1(vi1),
        .ack0(ack0), .ack1(ack1), .rv0(rv0), .rv1(rv1), .vo(vo),
        .m_ai(m_ai), .m_vi(m_vi), .m_we(m_we), .m_bmsk(m_bmsk), .m_vo(m_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        m_vo = 32'h0;
    end

    // SRAM model: byte-masked write, registered read data
    always @(posedge clk) begin
        if (m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_bmsk[b]) mem[m_ai][b*8 +: 8] <= m_vi[b*8 +: 8];
            end
        end
        m_vo <= mem[m_ai];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic exp_g1 [0:9];

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        bmsk0 = 4'hF; bmsk1 = 4'hF; ai0 = '0; ai1 = '0; vi0 = '0; vi1 = '0;
        exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        settle();

        // 1. reset with both requests asserted
        for (int c = 0; c < 2; c++) begin
            chk("rst_ack0", 32'(ack0), 32'd0);
            chk("rst_ack1", 32'(ack1), 32'd0);
            chk("rst_m_we", 32'(m_we), 32'd0);
            chk("rst_rv0",  32'(rv0),  32'd0);
            chk("rst_rv1",  32'(rv1),  32'd0);
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        step();
        chk("idle_rv0", 32'(rv0), 32'd0);
        chk("idle_m_we", 32'(m_we), 32'd0);

        // 2. M0 full-word write then read back
        req0 = 1'b1; we0 = 1'b1; ai0 = 15'h0010; vi0 = 32'h1234_5678; bmsk0 = 4'hF;
        settle();
        chk("wr0_ack0", 32'(ack0), 32'd1);
        chk("wr0_m_we", 32'(m_we), 32'd1);
        chk("wr0_bmsk", 32'(m_bmsk), 32'hF);
        chk("wr0_m_ai", 32'(m_ai), 32'h10);
        step();
        we0 = 1'b0;
        settle();
        chk("rd0_ack0", 32'(ack0), 32'd1);
        chk("rd0_m_we", 32'(m_we), 32'd0);
        chk("rd0_bmsk", 32'(m_bmsk), 32'h0);
        chk("wr0_no_rv", 32'(rv0), 32'd0);
        step();
        req0 = 1'b0;
        settle();
        chk("rd0_rv0", 32'(rv0), 32'd1);
        chk("rd0_rv1", 32'(rv1), 32'd0);
        chk("rd0_vo",  vo, 32'h1234_5678);
        step();
        chk("rd0_pulse", 32'(rv0), 32'd0);

        // 5. high bank write by M1, then M0 read low then M1 read high
        req1 = 1'b1; we1 = 1'b1; ai1 = 15'h4000; vi1 = 32'hDEAD_BEEF; bmsk1 = 4'hF;
        settle();
        chk("hb_wr_ack1", 32'(ack1), 32'd1);
        chk("hb_wr_ack0", 32'(ack0), 32'd0);
        chk("hb_wr_m_ai", 32'(m_ai), 32'h4000);
        step();
        we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; ai0 = 15'h0000;
        settle();
        chk("hb_pri_ack0", 32'(ack0), 32'd1);
        chk("hb_pri_ack1", 32'(ack1), 32'd0);
        chk("hb_wr_no_rv1", 32'(rv1), 32'd0);
        step();
        req0 = 1'b0;
        settle();
        chk("hb_rd1_ack1", 32'(ack1), 32'd1);
        chk("hb_rv0", 32'(rv0), 32'd1);
        chk("hb_vo0", vo, 32'h0);
        step();
        req1 = 1'b0;
        settle();
        chk("hb_rv1", 32'(rv1), 32'd1);
        chk("hb_rv0_off", 32'(rv0), 32'd0);
        chk("hb_vo1", vo, 32'hDEAD_BEEF);
        step();

        // 3. partial byte mask write over address 0
        req0 = 1'b1; we0 = 1'b1; ai0 = 15'h0000; vi0 = 32'hAABB_CCDD; bmsk0 = 4'b0101;
        settle();
        chk("bm_bmsk", 32'(m_bmsk), 32'h5);
        step();
        we0 = 1'b0;
        step();
        req0 = 1'b0;
        settle();
        chk("bm_rv0", 32'(rv0), 32'd1);
        chk("bm_vo", vo, 32'h00BB_00DD);
        step();

        // 4. starvation limit with both masters reading continuously
        req0 = 1'b1; we0 = 1'b0; ai0 = 15'h0010;
        req1 = 1'b1; we1 = 1'b0; ai1 = 15'h4000;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk($sformatf("sv_ack1_%0d", c), 32'(ack1), 32'(exp_g1[c]));
            chk($sformatf("sv_ack0_%0d", c), 32'(ack0), 32'(!exp_g1[c]));
            if (c > 0) begin
                chk($sformatf("sv_rv1_%0d", c), 32'(rv1), 32'(exp_g1[c-1]));
                chk($sformatf("sv_rv0_%0d", c), 32'(rv0), 32'(!exp_g1[c-1]));
                chk($sformatf("sv_vo_%0d", c), vo,
                    exp_g1[c-1] ? 32'hDEAD_BEEF : 32'h1234_5678);
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // 6. reset while an M1 read is in flight
        req1 = 1'b1; we1 = 1'b0; ai1 = 15'h4000;
        settle();
        chk("mr_ack1", 32'(ack1), 32'd1);
        step();
        rst = 1'b1; req1 = 1'b0; req0 = 1'b1;
        settle();
        chk("mr_rv1", 32'(rv1), 32'd0);
        chk("mr_ack0", 32'(ack0), 32'd0);
        step();
        rst = 1'b0; req0 = 1'b0;
        settle();
        chk("mr_rv1_after", 32'(rv1), 32'd0);
        chk("mr_rv0_after", 32'(rv0), 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        settle();
        chk("mr_post_ack0", 32'(ack0), 32'd1);
        chk("mr_post_ack1", 32'(ack1), 32'd0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
